mem_arbiter: RTL and testbench

- Two-requester arbiter and sequencer in front of the single-port 16-bit × 1024-word unified Memory. Requester 0 is instruction fetch; requester 1 is data load/store.
- The block owns the Memory's addr, data and MemWrite inputs. It pipelines one access per cycle.
- It returns read data to the requester that issued the access, with a fixed 2-cycle request-to-response latency.

---
 rtl/mem_pkg.sv | 26 ++
 rtl/rr_arbiter2.sv | 42 ++++
 rtl/mem_arbiter.sv | 144 ++++++++++++++
 tb/tb_mem_arbiter.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// ============================================================================
//  Module : mem_pkg
//  Brief  : Shared widths, port ids and counter helper for the memory arbiter.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mem_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int ADDR_WIDTH = 10;
    localparam int STAT_WIDTH = 16;

    typedef logic port_id_t;

    localparam port_id_t PORT_FETCH = 1'b0;
    localparam port_id_t PORT_DATA  = 1'b1;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [STAT_WIDTH-1:0] sat_inc(input logic [STAT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter2.sv
// ============================================================================
//  Module : rr_arbiter2
//  Brief  : Two-way round-robin grant; pointer names the port preferred on a tie.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_arbiter2
    import mem_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    port_id_t ptr;

    always_comb begin
        gnt = 2'b00;
        if (!reset) begin
            if (req == 2'b11) begin
                gnt = (ptr == PORT_DATA) ? 2'b10 : 2'b01;
            end else begin
                gnt = req;
            end
        end
    end

    // After a grant, prefer whichever port did not just win.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= PORT_FETCH;
        end else if (advance) begin
            ptr <= gnt[0] ? PORT_DATA : PORT_FETCH;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
//  Module : mem_arbiter
//  Brief  : Fetch/data arbiter and one-access-per-cycle sequencer for the
//           unified single-port memory; 2-cycle request-to-response latency.
//           Optional statistics counters enabled by macro MEM_ARB_STATS_EN.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_arbiter
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH = mem_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = mem_pkg::ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  rvalid0,
    output logic                  rvalid1,
    output logic [DATA_WIDTH-1:0] rdata0,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_write,
    input  logic [DATA_WIDTH-1:0] mem_out,
    output logic [STAT_WIDTH-1:0] stat_gnt0,
    output logic [STAT_WIDTH-1:0] stat_gnt1,
    output logic [STAT_WIDTH-1:0] stat_conflict
);

    logic [1:0]            gnt;
    logic                  issue_valid;
    logic                  issue_we;
    port_id_t              issue_port;
    logic [ADDR_WIDTH-1:0] issue_addr;
    logic [DATA_WIDTH-1:0] issue_data;
    logic                  read_done0;
    logic                  read_done1;

    rr_arbiter2 u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     ({req1, req0}),
        .advance (|gnt),
        .gnt     (gnt)
    );

    assign gnt0 = gnt[0];
    assign gnt1 = gnt[1];

    // Operands load only on a grant so the memory bus holds while idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            issue_valid <= 1'b0;
            issue_we    <= 1'b0;
            issue_port  <= PORT_FETCH;
            issue_addr  <= '0;
            issue_data  <= '0;
        end else begin
            issue_valid <= |gnt;
            if (gnt[1]) begin
                issue_port <= PORT_DATA;
                issue_we   <= we1;
                issue_addr <= addr1;
                issue_data <= wdata1;
            end else if (gnt[0]) begin
                issue_port <= PORT_FETCH;
                issue_we   <= we0;
                issue_addr <= addr0;
                issue_data <= wdata0;
            end
        end
    end

    assign mem_addr  = issue_addr;
    assign mem_data  = issue_data;
    assign mem_write = issue_valid & issue_we;

    assign read_done0 = issue_valid & ~issue_we & (issue_port == PORT_FETCH);
    assign read_done1 = issue_valid & ~issue_we & (issue_port == PORT_DATA);

    always_ff @(posedge clk) begin
        if (reset) begin
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            rdata0  <= '0;
            rdata1  <= '0;
        end else begin
            rvalid0 <= read_done0;
            rvalid1 <= read_done1;
            if (read_done0) begin
                rdata0 <= mem_out;
            end
            if (read_done1) begin
                rdata1 <= mem_out;
            end
        end
    end

`ifdef MEM_ARB_STATS_EN
    logic [STAT_WIDTH-1:0] cnt_gnt0;
    logic [STAT_WIDTH-1:0] cnt_gnt1;
    logic [STAT_WIDTH-1:0] cnt_conflict;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_gnt0     <= '0;
            cnt_gnt1     <= '0;
            cnt_conflict <= '0;
        end else begin
            if (gnt[0]) begin
                cnt_gnt0 <= sat_inc(cnt_gnt0);
            end
            if (gnt[1]) begin
                cnt_gnt1 <= sat_inc(cnt_gnt1);
            end
            if (req0 & req1) begin
                cnt_conflict <= sat_inc(cnt_conflict);
            end
        end
    end

    assign stat_gnt0     = cnt_gnt0;
    assign stat_gnt1     = cnt_gnt1;
    assign stat_conflict = cnt_conflict;
`else
    assign stat_gnt0     = '0;
    assign stat_gnt1     = '0;
    assign stat_conflict = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
//  Module : tb_mem_arbiter
//  Brief  : Directed vector bench for mem_arbiter with a falling-edge memory model.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter;
    import mem_pkg::*;

    logic        clk;
    logic        reset;
    logic        req0, req1, we0, we1;
    logic [9:0]  addr0, addr1;
    logic [15:0] wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1;
    logic [15:0] rdata0, rdata1;
    logic [9:0]  mem_addr;
    logic [15:0] mem_data;
    logic        mem_write;
    logic [15:0] mem_out;
    logic [15:0] stat_gnt0, stat_gnt1, stat_conflict;

    int errors = 0;
    int checks = 0;

    mem_arbiter dut (
        .clk           (clk),
        .reset         (reset),
        .req0          (req0),
        .req1          (req1),
        .we0           (we0),
        .we1           (we1),
        .addr0         (addr0),
        .addr1         (addr1),
        .wdata0        (wdata0),
        .wdata1        (wdata1),
        .gnt0          (gnt0),
        .gnt1          (gnt1),
        .rvalid0       (rvalid0),
        .rvalid1       (rvalid1),
        .rdata0        (rdata0),
        .rdata1        (rdata1),
        .mem_addr      (mem_addr),
        .mem_data      (mem_data),
        .mem_write     (mem_write),
        .mem_out       (mem_out),
        .stat_gnt0     (stat_gnt0),
        .stat_gnt1     (stat_gnt1),
        .stat_conflict (stat_conflict)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Unified memory: writes and address latch on the falling edge, read-new.
    logic [15:0] mem [0:1023];
    logic [9:0]  raddr;
    assign mem_out = mem[raddr];

    always @(negedge clk) begin
        if (mem_write) mem[mem_addr] = mem_data;
        raddr = mem_addr;
    end

    typedef struct packed {
        logic        rst;
        logic        r0, w0;
        logic [9:0]  a0;
        logic [15:0] d0;
        logic        r1, w1;
        logic [9:0]  a1;
        logic [15:0] d1;
        logic        eg0, eg1, ev0, ev1;
        logic [15:0] erd0, erd1;
        logic        emw;
        logic [9:0]  ema;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic rst, r0, w0, input logic [9:0] a0, input logic [15:0] d0,
                       input logic r1, w1, input logic [9:0] a1, input logic [15:0] d1,
                       input logic eg0, eg1, ev0, ev1, input logic [15:0] erd0, erd1,
                       input logic emw, input logic [9:0] ema);
        vec_t v;
        v = {rst, r0, w0, a0, d0, r1, w1, a1, d1, eg0, eg1, ev0, ev1, erd0, erd1, emw, ema};
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, r0, w0, input logic [9:0] a0, input logic [15:0] d0,
                         input logic r1, w1, input logic [9:0] a1, input logic [15:0] d1);
        reset = rst;
        req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
        req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
    endtask

    logic [1:0] hexp [0:4];
    logic [15:0] e_g0, e_g1, e_cf;

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
        mem[10'h005] = 16'hBEEF;
        mem[10'h010] = 16'h1010;
        mem[10'h020] = 16'h2020;
        mem[10'h007] = 16'h0707;
        raddr = 10'h000;
        drive(1'b1, 1'b0, 1'b0, 10'h0, 16'h0, 1'b0, 1'b0, 10'h0, 16'h0);

        //   rst   r0    w0    a0      d0        r1    w1    a1      d1        g0    g1    v0    v1    rd0       rd1       mw    ma
        add(1'b1, 1'b0, 1'b0, 10'h000, 16'h0000, 1'b0, 1'b0, 10'h000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 10'h000);
        add(1'b0, 1'b1, 1'b0, 10'h005, 16'h0000, 1'b0, 1'b0, 10'h000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 10'h000);
        add(1'b0, 1'b0, 1'b0, 10'h000, 16'h0000, 1'b0, 1'b0, 10'h000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 10'h005);
        add(1'b0, 1'b0, 1'b0, 10'h000, 16'h0000, 1'b0, 1'b0, 10'h000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 16'hBEEF, 16'h0000, 1'b0, 10'h005);
        add(1'b0, 1'b0, 1'b0, 10'h000, 16'h0000, 1'b1, 1'b1, 10'h3FF, 16'h1234, 1'b0, 1'b1, 1'b0, 1'b0, 16'hBEEF, 16'h0000, 1'b0, 10'h005);
        add(1'b0, 1'b0, 1'b0, 10'h000, 16'h0000, 1'b1, 1'b0, 10'h3FF, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 16'hBEEF, 16'h0000, 1'b1, 10'h3FF);
        add(1'b0, 1'b0, 1'b0, 10'h000, 16'h0000, 1'b0, 1'b0, 10'h000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'hBEEF, 16'h0000, 1'b0, 10'h3FF);
        add(1'b0, 1'b0, 1'b0, 10'h000, 16'h0000, 1'b0, 1'b0, 10'h000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 16'hBEEF, 16'h1234, 1'b0, 10'h3FF);
        add(1'b0, 1'b1, 1'b0, 10'h010, 16'h0000, 1'b1, 1'b0, 10'h020, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'hBEEF, 16'h1234, 1'b0, 10'h3FF);
        add(1'b0, 1'b1, 1'b0, 10'h010, 16'h0000, 1'b1, 1'b0, 10'h020, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 16'hBEEF, 16'h1234, 1'b0, 10'h010);
        add(1'b0, 1'b1, 1'b0, 10'h010, 16'h0000, 1'b1, 1'b0, 10'h020, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 16'h1010, 16'h1234, 1'b0, 10'h020);
        add(1'b0, 1'b1, 1'b0, 10'h010, 16'h0000, 1'b1, 1'b0, 10'h020, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 16'h1010, 16'h2020, 1'b0, 10'h010);
        add(1'b0, 1'b1, 1'b0, 10'h010, 16'h0000, 1'b1, 1'b0, 10'h020, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 16'h1010, 16'h2020, 1'b0, 10'h020);
        add(1'b0, 1'b1, 1'b0, 10'h010, 16'h0000, 1'b1, 1'b0, 10'h020, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 16'h1010, 16'h2020, 1'b0, 10'h010);
        add(1'b0, 1'b0, 1'b0, 10'h000, 16'h0000, 1'b0, 1'b0, 10'h000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 16'h1010, 16'h2020, 1'b0, 10'h020);
        add(1'b0, 1'b0, 1'b0, 10'h000, 16'h0000, 1'b0, 1'b0, 10'h000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 16'h1010, 16'h2020, 1'b0, 10'h020);
        add(1'b0, 1'b1, 1'b0, 10'h005, 16'h0000, 1'b0, 1'b0, 10'h000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h1010, 16'h2020, 1'b0, 10'h020);
        add(1'b0, 1'b1, 1'b0, 10'h005, 16'h0000, 1'b0, 1'b0, 10'h000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h1010, 16'h2020, 1'b0, 10'h005);
        add(1'b0, 1'b1, 1'b0, 10'h3FF, 16'h0000, 1'b0, 1'b0, 10'h000, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 16'hBEEF, 16'h2020, 1'b0, 10'h005);
        add(1'b0, 1'b1, 1'b0, 10'h3FF, 16'h0000, 1'b0, 1'b0, 10'h000, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 16'hBEEF, 16'h2020, 1'b0, 10'h3FF);
        add(1'b0, 1'b0, 1'b0, 10'h000, 16'h0000, 1'b0, 1'b0, 10'h000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 16'h1234, 16'h2020, 1'b0, 10'h3FF);
        add(1'b0, 1'b0, 1'b0, 10'h000, 16'h0000, 1'b0, 1'b0, 10'h000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 16'h1234, 16'h2020, 1'b0, 10'h3FF);
        add(1'b0, 1'b0, 1'b0, 10'h000, 16'h0000, 1'b0, 1'b0, 10'h000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h1234, 16'h2020, 1'b0, 10'h3FF);
        add(1'b0, 1'b1, 1'b0, 10'h005, 16'h0000, 1'b0, 1'b0, 10'h000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h1234, 16'h2020, 1'b0, 10'h3FF);
        add(1'b1, 1'b0, 1'b0, 10'h000, 16'h0000, 1'b1, 1'b1, 10'h007, 16'hDEAD, 1'b0, 1'b0, 1'b0, 1'b0, 16'h1234, 16'h2020, 1'b0, 10'h005);
        add(1'b0, 1'b0, 1'b0, 10'h000, 16'h0000, 1'b0, 1'b0, 10'h000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 10'h000);
        add(1'b0, 1'b0, 1'b0, 10'h000, 16'h0000, 1'b0, 1'b0, 10'h000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 10'h000);

        repeat (2) @(posedge clk);

        // Inputs change 1 after the rising edge; outputs sampled 4 after it.
        for (int i = 0; i < vq.size(); i++) begin
            @(posedge clk);
            #1;
            drive(vq[i].rst, vq[i].r0, vq[i].w0, vq[i].a0, vq[i].d0,
                  vq[i].r1, vq[i].w1, vq[i].a1, vq[i].d1);
            #3;
            chk($sformatf("c%0d gnt0", i),      32'(gnt0),      32'(vq[i].eg0));
            chk($sformatf("c%0d gnt1", i),      32'(gnt1),      32'(vq[i].eg1));
            chk($sformatf("c%0d rvalid0", i),   32'(rvalid0),   32'(vq[i].ev0));
            chk($sformatf("c%0d rvalid1", i),   32'(rvalid1),   32'(vq[i].ev1));
            chk($sformatf("c%0d rdata0", i),    32'(rdata0),    32'(vq[i].erd0));
            chk($sformatf("c%0d rdata1", i),    32'(rdata1),    32'(vq[i].erd1));
            chk($sformatf("c%0d mem_write", i), 32'(mem_write), 32'(vq[i].emw));
            chk($sformatf("c%0d mem_addr", i),  32'(mem_addr),  32'(vq[i].ema));
            chk($sformatf("c%0d gnt_excl", i),  32'(gnt0 & gnt1), 32'(0));
        end

        // Statistics: 3 conflict cycles then 2 solo port-0 cycles after reset.
        hexp[0] = 2'b01; hexp[1] = 2'b10; hexp[2] = 2'b01; hexp[3] = 2'b01; hexp[4] = 2'b01;
        for (int h = 0; h < 5; h++) begin
            @(posedge clk);
            #1;
            drive(1'b0, 1'b1, 1'b0, 10'h010, 16'h0000, (h < 3), 1'b0, 10'h020, 16'h0000);
            #3;
            chk($sformatf("h%0d gnt", h), 32'({gnt1, gnt0}), 32'(hexp[h]));
        end
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 1'b0, 10'h000, 16'h0000, 1'b0, 1'b0, 10'h000, 16'h0000);
        #3;
`ifdef MEM_ARB_STATS_EN
        e_g0 = 16'd4; e_g1 = 16'd1; e_cf = 16'd3;
`else
        e_g0 = 16'd0; e_g1 = 16'd0; e_cf = 16'd0;
`endif
        chk("stat_gnt0",     32'(stat_gnt0),     32'(e_g0));
        chk("stat_gnt1",     32'(stat_gnt1),     32'(e_g1));
        chk("stat_conflict", 32'(stat_conflict), 32'(e_cf));

        repeat (3) @(posedge clk);
        #4;
        chk("mem 0x007 untouched", 32'(mem[10'h007]), 32'(16'h0707));
        chk("mem 0x3FF written",   32'(mem[10'h3FF]), 32'(16'h1234));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
